// File: rtl/pc_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pc_sequencer_pkg
// Definitions shared by the fetch sequencer: the FSM state encoding, the
// default reset PC, the sequential PC increment, and a helper that
// word-aligns redirect targets.
// -----------------------------------------------------------------------------
package pc_sequencer_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] PC_INCR          = 32'd4;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,  // request outstanding on imem
        ST_HOLD  = 2'd1,  // word returned, downstream stalled, no request
        ST_DRAIN = 2'd2   // redirect latched, waiting out the old request
    } seq_state_e;

    // Instruction addresses are word aligned; the low two bits of any
    // redirect target are discarded.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage : pc_sequencer_pkg

// File: rtl/pc_sequencer_pc_incr.sv
// -----------------------------------------------------------------------------
// pc_incr
// Sequential PC adder: pc_next_o = pc_i + 4, wrapping modulo 2^32.
//   pc_i      : current PC
//   pc_next_o : following word address
// -----------------------------------------------------------------------------
module pc_incr
    import pc_sequencer_pkg::*;
(
    input  logic [31:0] pc_i,
    output logic [31:0] pc_next_o
);

    assign pc_next_o = pc_i + PC_INCR;

endmodule : pc_incr

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Instruction fetch PC sequencer. Issues word reads to instruction memory,
// presents returned words to IF/ID, holds them under downstream stall, and
// applies jump/branch redirects (jump has priority over branch).
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   stall                 : IF/ID cannot accept a word this cycle
//   br_taken, br_target   : taken-branch redirect (pulse) and target
//   jmp_valid, jmp_target : jump redirect (pulse) and target
//   imem_req, imem_addr   : instruction memory read request / word address
//   imem_ready            : memory returns the word for imem_addr this cycle
//   if_valid, if_pc       : fetched word valid, and its PC
//   if_npc                : if_pc + 4
//
// Optional feature (macro PC_SEQ_EXC_EN): adds exc_valid/exc_vector, an
// exception redirect above jump priority, and the epc output.
// -----------------------------------------------------------------------------
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp_valid,
    input  logic [31:0] jmp_target,
`ifdef PC_SEQ_EXC_EN
    input  logic        exc_valid,
    input  logic [31:0] exc_vector,
    output logic [31:0] epc,
`endif
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_npc
);

    seq_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;        // redirect target latched for DRAIN
    logic        imem_req_q, imem_req_d;
    logic [31:0] pc_plus4;
    logic        redirect;
    logic [31:0] redirect_raw;
    logic [31:0] redirect_target;
    logic        word_returned;

    pc_incr u_incr_next (.pc_i(pc_q),  .pc_next_o(pc_plus4));
    pc_incr u_incr_npc  (.pc_i(if_pc), .pc_next_o(if_npc));

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        redirect     = jmp_valid | br_taken;
        redirect_raw = jmp_valid ? jmp_target : br_target;
`ifdef PC_SEQ_EXC_EN
        if (exc_valid) begin
            redirect     = 1'b1;
            redirect_raw = exc_vector;
        end
`endif
    end

    assign redirect_target = align_word(redirect_raw);

    // The cycle right after reset has imem_req low; a ready seen then
    // belongs to no request of ours and is ignored.
    assign word_returned = imem_req_q & imem_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        unique case (state_q)
            ST_FETCH: begin
                if (redirect) begin
                    if (word_returned || !imem_req_q) begin
                        pc_d = redirect_target;
                    end else begin
                        tgt_d   = redirect_target;
                        state_d = ST_DRAIN;
                    end
                end else if (word_returned) begin
                    if (stall) state_d = ST_HOLD;
                    else       pc_d    = pc_plus4;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_d    = redirect_target;
                    state_d = ST_FETCH;
                end else if (!stall) begin
                    pc_d    = pc_plus4;
                    state_d = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                // A newer redirect replaces the latched one, even in the
                // cycle the stale word comes back.
                if (redirect) tgt_d = redirect_target;
                if (imem_ready) begin
                    pc_d    = redirect ? redirect_target : tgt_q;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
        imem_req_d = (state_d != ST_HOLD);
    end

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            tgt_q      <= '0;
            imem_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tgt_q      <= tgt_d;
            imem_req_q <= imem_req_d;
        end
    end

    // The PC only advances once a word is accepted, so the current PC is
    // both the outstanding request address and the PC of any held word.
    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign if_pc     = pc_q;
    assign if_valid  = !redirect &&
                       ((state_q == ST_HOLD) ||
                        (state_q == ST_FETCH && word_returned));

`ifdef PC_SEQ_EXC_EN
    logic [31:0] epc_q;

    // if_pc and the current PC coincide, so one capture covers both the
    // held-word and no-word cases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         epc_q <= '0;
        else if (exc_valid) epc_q <= pc_q;
    end

    assign epc = epc_q;
`endif

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Self-checking bench for pc_sequencer: a directed vector table, a
// reset-during-drain sequence, and randomized traffic against a reference
// model of the fetch rules.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, br_taken, jmp_valid, imem_ready;
    logic [31:0] br_target, jmp_target;
    logic        imem_req, if_valid;
    logic [31:0] imem_addr, if_pc, if_npc;
`ifdef PC_SEQ_EXC_EN
    logic        exc_valid = 1'b0;
    logic [31:0] exc_vector = '0;
    logic [31:0] epc;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jmp_valid  (jmp_valid),
        .jmp_target (jmp_target),
`ifdef PC_SEQ_EXC_EN
        .exc_valid  (exc_valid),
        .exc_vector (exc_vector),
        .epc        (epc),
`endif
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_npc     (if_npc)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] bt;
        logic        jmp;
        logic [31:0] jt;
        logic        ready;
        logic        exp_valid;
        logic        exp_req;
        logic [31:0] exp_pc;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic b, input logic [31:0] bt,
                                input logic j, input logic [31:0] jt, input logic r,
                                input logic ev, input logic eq, input logic [31:0] ep);
        vec_t v;
        v.stall = s; v.br = b; v.bt = bt; v.jmp = j; v.jt = jt; v.ready = r;
        v.exp_valid = ev; v.exp_req = eq; v.exp_pc = ep;
        return v;
    endfunction

    task automatic drive(input logic s, input logic b, input logic [31:0] bt,
                         input logic j, input logic [31:0] jt, input logic r);
        stall = s; br_taken = b; br_target = bt;
        jmp_valid = j; jmp_target = jt; imem_ready = r;
    endtask

    // Compare outputs against expectations; the PC fields only matter when
    // a word is presented or a request is outstanding.
    task automatic check_outputs(input string tag, input logic ev, input logic eq,
                                 input logic [31:0] ep);
        logic [31:0] npc;
        npc = ep + 32'd4;
        check({tag, ".if_valid"}, {31'd0, if_valid}, {31'd0, ev});
        check({tag, ".imem_req"}, {31'd0, imem_req}, {31'd0, eq});
        if (ev) begin
            check({tag, ".if_pc"},  if_pc,  ep);
            check({tag, ".if_npc"}, if_npc, npc);
        end
        if (eq) check({tag, ".imem_addr"}, imem_addr, ep);
    endtask

    // Reference model state: current PC, word being held under stall,
    // redirect waiting for the old request, and whether a request is out.
    logic [31:0] m_pc, m_tgt;
    logic        m_held, m_drain, m_req;

    task automatic model_step(input logic s, input logic b, input logic [31:0] bt,
                              input logic j, input logic [31:0] jt, input logic r);
        logic        redir;
        logic [31:0] tgt;
        redir = b | j;
        tgt   = (j ? jt : bt) & 32'hFFFF_FFFC;
        if (m_held) begin
            if (redir)   begin m_pc = tgt;         m_held = 1'b0; end
            else if (!s) begin m_pc = m_pc + 32'd4; m_held = 1'b0; end
        end else if (m_drain) begin
            if (redir) m_tgt = tgt;
            if (r) begin m_pc = m_tgt; m_drain = 1'b0; end
        end else if (redir) begin
            if (!m_req || r) m_pc = tgt;
            else begin m_tgt = tgt; m_drain = 1'b1; end
        end else if (m_req && r) begin
            if (s) m_held = 1'b1;
            else   m_pc   = m_pc + 32'd4;
        end
        m_req = !m_held;
    endtask

    vec_t vecs[$];

    initial begin
        // Directed table, one row per cycle starting one edge after reset.
        vecs.push_back(mk(0,0,0,            0,0,            1, 1,1,32'h3000));
        vecs.push_back(mk(0,0,0,            0,0,            0, 0,1,32'h3004));
        vecs.push_back(mk(0,0,0,            0,0,            0, 0,1,32'h3004));
        vecs.push_back(mk(0,0,0,            0,0,            0, 0,1,32'h3004));
        vecs.push_back(mk(0,0,0,            0,0,            1, 1,1,32'h3004));
        vecs.push_back(mk(1,0,0,            0,0,            1, 1,1,32'h3008));
        vecs.push_back(mk(1,0,0,            0,0,            1, 1,0,32'h3008));
        vecs.push_back(mk(0,0,0,            0,0,            1, 1,0,32'h3008));
        vecs.push_back(mk(0,0,0,            0,0,            1, 1,1,32'h300C));
        vecs.push_back(mk(0,1,32'h0000_4003,0,0,            0, 0,1,32'h3010));
        vecs.push_back(mk(0,0,0,            0,0,            0, 0,1,32'h3010));
        vecs.push_back(mk(0,0,0,            0,0,            1, 0,1,32'h3010));
        vecs.push_back(mk(0,0,0,            0,0,            1, 1,1,32'h4000));
        vecs.push_back(mk(0,1,32'h6000,     1,32'h5000,     1, 0,1,32'h4004));
        vecs.push_back(mk(0,0,0,            0,0,            1, 1,1,32'h5000));
        vecs.push_back(mk(0,0,0,            1,32'hFFFF_FFFF,1, 0,1,32'h5004));
        vecs.push_back(mk(0,0,0,            0,0,            1, 1,1,32'hFFFF_FFFC));
        vecs.push_back(mk(0,0,0,            0,0,            1, 1,1,32'h0));
        vecs.push_back(mk(1,0,0,            0,0,            1, 1,1,32'h4));
        vecs.push_back(mk(1,1,32'h102,      0,0,            1, 0,0,32'h4));
        vecs.push_back(mk(0,0,0,            0,0,            1, 1,1,32'h100));
        vecs.push_back(mk(0,1,32'h200,      0,0,            0, 0,1,32'h104));
        vecs.push_back(mk(0,0,0,            1,32'h301,      0, 0,1,32'h104));
        vecs.push_back(mk(0,0,0,            0,0,            1, 0,1,32'h104));
        vecs.push_back(mk(0,0,0,            0,0,            1, 1,1,32'h300));
        vecs.push_back(mk(0,0,0,            0,0,            0, 0,1,32'h304));

        // Reset values, with ready high to show it is ignored.
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 1);
        @(negedge clk); #1;
        check("reset.if_valid", {31'd0, if_valid}, 32'd0);
        check("reset.imem_req", {31'd0, imem_req}, 32'd0);
        check("reset.if_pc",    if_pc,  RST_PC);
        check("reset.if_npc",   if_npc, RST_PC + 32'd4);
        rst_n = 1'b1;
        #1;
        check("release.imem_req", {31'd0, imem_req}, 32'd0);
        check("release.if_valid", {31'd0, if_valid}, 32'd0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].stall, vecs[i].br, vecs[i].bt,
                  vecs[i].jmp, vecs[i].jt, vecs[i].ready);
            #1;
            check_outputs($sformatf("row%0d", i), vecs[i].exp_valid,
                          vecs[i].exp_req, vecs[i].exp_pc);
        end

        // Reset while draining: the stale request is abandoned silently.
        @(negedge clk);
        drive(0, 1, 32'h8000, 0, 0, 0);
        #1;
        check_outputs("drain_enter", 1'b0, 1'b1, 32'h304);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        check_outputs("drain_wait", 1'b0, 1'b1, 32'h304);
        rst_n = 1'b0;
        imem_ready = 1'b1;
        #1;
        check("drain_rst.if_valid", {31'd0, if_valid}, 32'd0);
        check("drain_rst.imem_req", {31'd0, imem_req}, 32'd0);
        check("drain_rst.if_pc",    if_pc, RST_PC);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("drain_rel.if_valid", {31'd0, if_valid}, 32'd0);
        @(negedge clk); #1;
        check_outputs("drain_after", 1'b1, 1'b1, RST_PC);

        // Randomized traffic against the reference model.
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk); #1;
        rst_n   = 1'b1;
        m_pc    = RST_PC;
        m_tgt   = '0;
        m_held  = 1'b0;
        m_drain = 1'b0;
        m_req   = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic        s, b, j, r, ev;
            logic [31:0] bt, jt;
            s  = ($urandom % 4) == 0;
            b  = ($urandom % 8) == 0;
            j  = ($urandom % 10) == 0;
            r  = ($urandom % 4) != 0;
            bt = $urandom;
            jt = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
            drive(s, b, bt, j, jt, r);
            #1;
            ev = !(b | j) && (m_held || (!m_drain && m_req && r));
            check_outputs($sformatf("rand%0d", i), ev, m_req, m_pc);
            model_step(s, b, bt, j, jt, r);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_pc_sequencer
